instr_fetch_unit: RTL

- Reads the current PC value and fetches the 16-bit instruction at that address over a req/ack memory handshake.
- Latches the instruction into an internal instruction register.
- Produces the PC write strobe and next-PC value that the program counter consumes.
- Sits between the multi-cycle control FSM, the program counter and instruction memory.

---
 rtl/instr_fetch_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
//============================================================================
// Module      : instr_fetch_unit
// Description : Fetches one 16-bit instruction per fetch_start request over a
//               req/ack memory handshake, latches it into the instruction
//               register and produces the PC write strobe / next-PC value.
//               A fetch that waits TIMEOUT_CYCLES ISSUE cycles without an
//               ack is aborted with a one-cycle fetch_error pulse.
// Optional    : define IFU_FETCH_COUNT_EN to add a saturating 16-bit count
//               of completed fetches on output fetch_count.
// Ports       : clk, proc_rst (async, active-high)
//               fetch_start, pc_value, branch_taken, branch_target  (control)
//               mem_req, mem_addr, mem_rdata, mem_ack             (memory)
//               ir_out, ir_valid, pc_write, pc_next               (results)
//               busy, fetch_error [, fetch_count]                 (status)
// Revision    : 1.0 - initial release
//============================================================================
module instr_fetch_unit #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              proc_rst,
    input  logic              fetch_start,
    input  logic [ADDR_W-1:0] pc_value,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    output logic              pc_write,
    output logic [ADDR_W-1:0] pc_next,
    output logic              busy,
`ifdef IFU_FETCH_COUNT_EN
    output logic [15:0]       fetch_count,
`endif
    output logic              fetch_error
);

    // Counter holds the number of ISSUE cycles already spent without an ack,
    // so it only needs to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_ir;
    logic [ADDR_W-1:0] r_pc_next;
    logic              w_expire;

    // Last permissible ISSUE cycle; an ack arriving here still wins.
    assign w_expire = (r_cnt == c_CNT_LAST);

    //------------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------------
    always_ff @(posedge clk or posedge proc_rst) begin
        if (proc_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //------------------------------------------------------------------------
    // Next-state and state-decoded outputs
    //------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        mem_req     = 1'b0;
        ir_valid    = 1'b0;
        pc_write    = 1'b0;
        fetch_error = 1'b0;
        busy        = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (fetch_start) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_state_nxt = S_DONE;
                end else if (w_expire) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_DONE: begin
                ir_valid    = 1'b1;
                pc_write    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_ERR: begin
                fetch_error = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // Datapath: fetch address, wait counter, IR and next-PC
    //------------------------------------------------------------------------
    always_ff @(posedge clk or posedge proc_rst) begin
        if (proc_rst) begin
            r_addr    <= '0;
            r_cnt     <= '0;
            r_ir      <= '0;
            r_pc_next <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Branch inputs matter only at the moment a fetch starts.
                    if (fetch_start) begin
                        r_addr <= branch_taken ? branch_target : pc_value;
                        r_cnt  <= '0;
                    end
                end
                S_ISSUE: begin
                    if (mem_ack) begin
                        r_ir      <= mem_rdata;
                        r_pc_next <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    end else if (!w_expire) begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr = r_addr;
    assign ir_out   = r_ir;
    assign pc_next  = r_pc_next;

`ifdef IFU_FETCH_COUNT_EN
    //------------------------------------------------------------------------
    // Saturating count of completed (acked) fetches
    //------------------------------------------------------------------------
    logic [15:0] r_fetch_count;

    always_ff @(posedge clk or posedge proc_rst) begin
        if (proc_rst) begin
            r_fetch_count <= '0;
        end else if ((r_state == S_DONE) && (r_fetch_count != 16'hFFFF)) begin
            r_fetch_count <= r_fetch_count + 16'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

endmodule
`default_nettype wire
